// File: rtl/seg_scan_decoder.sv
// Rebuilds four BCD digits and decimal points from a multiplexed active-low 7-seg bus.
// Capture on the SETTLE-th identical sample, frame_valid one edge after the 4th position; passive monitor, no backpressure.
module seg_scan_decoder #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  Seg,
  input  logic        decimal,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic        frame_valid,
  output logic        glyph_err,
  output logic        stale
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);
  localparam logic [SW-1:0] CAP_CNT    = SW'(SETTLE - 2);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_HIT     = TW'(TIMEOUT - 1);

  typedef enum logic {SCAN, STALE} state_t;
  state_t state, state_nxt;

  logic [11:0]     in_vec, s_q;
  logic [SW-1:0]   stable_cnt;
  logic [TW-1:0]   to_cnt;
  logic [3:0]      seen, seen_nxt;
  logic [3:0][3:0] shadow_d;
  logic [3:0]      shadow_p;
  logic [3:0]      an_lo;
  logic [6:0]      seg_hi;
  logic            dp_lit;
  logic            same, capture, frame_done;
  logic [1:0]      cap_pos;
  logic [3:0]      glyph_val;
  logic            glyph_bad;
  logic            unused_seg7;

  assign unused_seg7 = Seg[7];
  assign in_vec      = {an, Seg[6:0], decimal};
  assign same        = (in_vec == s_q);
  assign an_lo       = ~s_q[11:8];
  assign seg_hi      = ~s_q[7:1];
  assign dp_lit      = ~s_q[0];
  assign frame_done  = (seen == 4'b1111);
  // stable_cnt passes SETTLE-2 exactly once per run, so this fires once per stable run
  assign capture     = same && (stable_cnt == CAP_CNT) && $onehot(an_lo);
  assign stale       = (state == STALE);

  always_comb begin
    cap_pos = 2'd0;
    case (an_lo)
      4'b0010: cap_pos = 2'd1;
      4'b0100: cap_pos = 2'd2;
      4'b1000: cap_pos = 2'd3;
      default: cap_pos = 2'd0;
    endcase
  end

  always_comb begin
    glyph_val = 4'hE;
    glyph_bad = 1'b0;
    case (seg_hi)
      7'h3F: glyph_val = 4'd0;
      7'h06: glyph_val = 4'd1;
      7'h5B: glyph_val = 4'd2;
      7'h4F: glyph_val = 4'd3;
      7'h66: glyph_val = 4'd4;
      7'h6D: glyph_val = 4'd5;
      7'h7D: glyph_val = 4'd6;
      7'h07: glyph_val = 4'd7;
      7'h7F: glyph_val = 4'd8;
      7'h6F: glyph_val = 4'd9;
      7'h00: glyph_val = 4'hF;
      default: glyph_bad = 1'b1;
    endcase
  end

  // A capture on a frame or timeout edge belongs to the next frame, so it is applied after the clear
  always_comb begin
    state_nxt = state;
    seen_nxt  = seen;
    case (state)
      SCAN: begin
        if (frame_done) begin
          seen_nxt = 4'b0000;
        end else if (to_cnt == TO_HIT) begin
          seen_nxt  = 4'b0000;
          state_nxt = STALE;
        end
      end
      STALE: begin
        if (frame_done) begin
          seen_nxt  = 4'b0000;
          state_nxt = SCAN;
        end
      end
      default: state_nxt = SCAN;
    endcase
    if (capture) seen_nxt[cap_pos] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCAN;
      seen  <= 4'b0000;
    end else begin
      state <= state_nxt;
      seen  <= seen_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q         <= '1;
      stable_cnt  <= '0;
      to_cnt      <= '0;
      shadow_d    <= '1;
      shadow_p    <= '0;
      digits      <= 16'hFFFF;
      dps         <= '0;
      frame_valid <= 1'b0;
      glyph_err   <= 1'b0;
    end else begin
      s_q <= in_vec;
      if (!same)                         stable_cnt <= '0;
      else if (stable_cnt != SETTLE_MAX) stable_cnt <= stable_cnt + SW'(1);
      if (frame_done)            to_cnt <= '0;
      else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);
      frame_valid <= frame_done;
      glyph_err   <= capture && glyph_bad;
      if (frame_done) begin
        digits <= shadow_d;
        dps    <= shadow_p;
      end
      if (capture) begin
        shadow_d[cap_pos] <= glyph_val;
        shadow_p[cap_pos] <= dp_lit;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a run-length reference model predicts frames,
// glyph errors and stale transitions with edge stamps; a negedge monitor pops and compares.
module tb_seg_scan_decoder;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  Seg;
  logic        decimal;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic        frame_valid, glyph_err, stale;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .Seg(Seg), .decimal(decimal), .an(an),
    .digits(digits), .dps(dps), .frame_valid(frame_valid),
    .glyph_err(glyph_err), .stale(stale)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int frames_obs = 0;
  int glyphs_obs = 0;

  typedef struct packed { int unsigned e; logic [15:0] d; logic [3:0] p; } frame_t;
  typedef struct packed { int unsigned e; logic v; } stale_t;
  frame_t      frame_q[$];
  int unsigned glyph_q[$];
  stale_t      stale_q[$];

  logic [6:0] glyph_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model state: the last sampled vector and how many consecutive samples it has lasted
  logic [11:0]     m_prev = '1;
  int              m_run = 1;
  logic [3:0]      m_seen = '0;
  logic [3:0][3:0] m_sd = '1;
  logic [3:0]      m_sp = '0;
  bit              m_stale = 1'b0;
  int unsigned     m_clear = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [3:0] decode(input logic [6:0] g);
    if (g == 7'h00) return 4'hF;
    for (int i = 0; i < 10; i++) if (glyph_tbl[i] == g) return 4'(i);
    return 4'hE;
  endfunction

  // Predict what the upcoming edge does with the inputs just driven
  task automatic model_edge(input bit rst, input logic [3:0] a, input logic [6:0] g, input bit dp);
    int unsigned e;
    logic [11:0] v;
    int lows, k;
    logic [3:0] dv;
    e = edge_cnt + 1;
    v = {a, ~g, ~dp};
    if (rst) begin
      if (m_stale) stale_q.push_back('{e: e, v: 1'b0});
      m_stale = 1'b0; m_seen = '0; m_sd = '1; m_sp = '0;
      m_prev = '1; m_run = 1; m_clear = e;
      return;
    end
    if (v == m_prev) m_run++;
    else begin m_prev = v; m_run = 1; end
    if (m_seen == 4'hF) begin
      frame_q.push_back('{e: e, d: m_sd, p: m_sp});
      m_seen = '0; m_clear = e;
      if (m_stale) stale_q.push_back('{e: e, v: 1'b0});
      m_stale = 1'b0;
    end else if (!m_stale && (e - m_clear) == TIMEOUT) begin
      m_stale = 1'b1; m_seen = '0;
      stale_q.push_back('{e: e, v: 1'b1});
    end
    lows = 0; k = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) begin lows++; k = i; end
    if (m_run == SETTLE && lows == 1) begin
      dv = decode(g);
      m_sd[k] = dv; m_sp[k] = dp; m_seen[k] = 1'b1;
      if (dv == 4'hE) glyph_q.push_back(e);
    end
  endtask

  task automatic step(input bit rst, input logic [3:0] a, input logic [6:0] g, input bit dp, input int n);
    for (int i = 0; i < n; i++) begin
      reset = rst; an = a; Seg = {1'($urandom), ~g}; decimal = ~dp;
      model_edge(rst, a, g, dp);
      @(posedge clk); #1;
    end
  endtask

  task automatic scan_pos(input int k, input logic [6:0] g, input bit dp, input int hold);
    step(1'b0, 4'(~(4'b0001 << k)), g, dp, hold);
  endtask

  task automatic scan4(input logic [3:0][6:0] g, input logic [3:0] dpm, input int hold);
    for (int k = 0; k < 4; k++) scan_pos(k, g[k], dpm[k], hold);
  endtask

  always @(negedge clk) begin
    frame_t f;
    stale_t s;
    logic   stale_prev;
    if (edge_cnt == 0) stale_prev = 1'b0;
    else begin
      if (frame_valid === 1'b1) begin
        frames_obs++;
        if (frame_q.size() == 0) check("frame_unexpected", {16'h0, digits}, 32'hFFFF_FFFF);
        else begin
          f = frame_q.pop_front();
          check("frame_edge", edge_cnt, f.e);
          check("frame_digits", {16'h0, digits}, {16'h0, f.d});
          check("frame_dps", {28'h0, dps}, {28'h0, f.p});
        end
      end
      if (glyph_err === 1'b1) begin
        glyphs_obs++;
        if (glyph_q.size() == 0) check("glyph_unexpected", edge_cnt, 32'hFFFF_FFFF);
        else check("glyph_edge", edge_cnt, glyph_q.pop_front());
      end
      if (stale !== stale_prev) begin
        if (stale_q.size() == 0) check("stale_unexpected", {31'h0, stale}, {31'h0, stale_prev});
        else begin
          s = stale_q.pop_front();
          check("stale_edge", edge_cnt, s.e);
          check("stale_value", {31'h0, stale}, {31'h0, s.v});
        end
        stale_prev = stale;
      end
    end
  end

  logic [3:0][6:0] g1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
  logic [3:0][6:0] gbad  = {7'h06, 7'h5B, 7'h49, 7'h66};
  int f0, e0, rst_edge, r, ra, rg;
  logic [3:0] a_r;
  logic [6:0] g_r;

  initial begin
    reset = 1'b1; an = '1; Seg = '1; decimal = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 4'($urandom), 7'($urandom), 1'($urandom), 1);
    check("rst_digits", {16'h0, digits}, 32'h0000_FFFF);
    check("rst_dps", {28'h0, dps}, 32'h0);
    check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_glyph_err", {31'h0, glyph_err}, 32'h0);
    check("rst_stale", {31'h0, stale}, 32'h0);
    step(1'b0, 4'hF, 7'h00, 1'b0, 2);

    f0 = frames_obs;
    for (int s = 0; s < 3; s++) scan4(g1234, 4'b0100, 10);
    check("scan_frames", frames_obs - f0, 3);
    check("scan_digits", {16'h0, digits}, 32'h0000_1234);
    check("scan_dps", {28'h0, dps}, 32'h0000_0004);

    step(1'b1, 4'hF, 7'h00, 1'b0, 1);
    step(1'b0, 4'hF, 7'h00, 1'b0, 2);
    f0 = frames_obs;
    for (int k = 1; k < 4; k++) scan_pos(k, g1234[k], k == 2, 10);
    scan_pos(0, 7'h7F, 1'b0, SETTLE - 1);
    step(1'b0, 4'hF, 7'h00, 1'b0, 5);
    check("settle_short_no_frame", frames_obs - f0, 0);
    scan_pos(0, 7'h7F, 1'b0, SETTLE);
    step(1'b0, 4'hF, 7'h00, 1'b0, 3);
    check("settle_full_frame", frames_obs - f0, 1);
    check("settle_digits", {16'h0, digits}, 32'h0000_1238);

    f0 = frames_obs; e0 = glyphs_obs;
    scan4(gbad, 4'b0100, 10);
    check("illegal_glyph_pulses", glyphs_obs - e0, 1);
    check("illegal_digits", {16'h0, digits}, 32'h0000_12E4);
    f0 = frames_obs; e0 = glyphs_obs;
    step(1'b0, 4'b1100, 7'h3F, 1'b0, 20);
    check("ambiguous_no_frame", frames_obs - f0, 0);
    check("ambiguous_no_error", glyphs_obs - e0, 0);

    step(1'b1, 4'hF, 7'h00, 1'b0, 1);
    rst_edge = edge_cnt;
    for (int k = 0; k < 3; k++) scan_pos(k, g1234[k], k == 2, 10);
    step(1'b0, 4'hF, 7'h00, 1'b0, TIMEOUT - 31 - (edge_cnt - rst_edge - 30));
    check("timeout_not_yet", {31'h0, stale}, 32'h0);
    check("timeout_edge_pos", edge_cnt - rst_edge, TIMEOUT - 1);
    step(1'b0, 4'hF, 7'h00, 1'b0, 1);
    check("timeout_stale", {31'h0, stale}, 32'h1);
    step(1'b0, 4'hF, 7'h00, 1'b0, 5);
    f0 = frames_obs;
    scan_pos(3, g1234[3], 1'b0, 10);
    check("timeout_partial_discarded", frames_obs - f0, 0);
    scan4(g1234, 4'b0100, 10);
    check("timeout_resume_frame", frames_obs - f0, 1);
    check("timeout_stale_cleared", {31'h0, stale}, 32'h0);

    for (int k = 0; k < 2; k++) scan_pos(k, g1234[k], 1'b0, 10);
    step(1'b1, 4'hF, 7'h00, 1'b0, 1);
    step(1'b0, 4'hF, 7'h00, 1'b0, 2);
    f0 = frames_obs;
    for (int k = 2; k < 4; k++) scan_pos(k, g1234[k], k == 2, 10);
    step(1'b0, 4'hF, 7'h00, 1'b0, 3);
    check("midreset_no_frame", frames_obs - f0, 0);
    scan4(g1234, 4'b0100, 10);
    check("midreset_rescan_frame", frames_obs - f0, 1);

    for (int it = 0; it < 600; it++) begin
      ra = $urandom_range(0, 9);
      if (ra <= 6) a_r = 4'(~(4'b0001 << $urandom_range(0, 3)));
      else if (ra == 7) a_r = 4'hF;
      else a_r = 4'($urandom);
      rg = $urandom_range(0, 11);
      if (rg < 10) g_r = glyph_tbl[rg];
      else if (rg == 10) g_r = 7'h00;
      else g_r = 7'($urandom);
      r = $urandom_range(0, 79);
      if (r == 0) step(1'b1, a_r, g_r, 1'($urandom), 1);
      else step(1'b0, a_r, g_r, 1'($urandom), $urandom_range(1, 8));
    end

    step(1'b0, 4'hF, 7'h00, 1'b0, 5);
    check("frame_queue_drained", frame_q.size(), 0);
    check("glyph_queue_drained", glyph_q.size(), 0);
    check("stale_queue_drained", stale_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
